// File: rtl/game_stats_pkg.sv
// Shared game encodings: game-control phases and the stats FSM states,
// plus elaboration-time helpers for splitting constants into BCD digits.
package game_stats_pkg;

   typedef enum logic [1:0] {
      CHOSE_BOARD  = 2'b00,
      GAMING       = 2'b01,
      GAME_INITIAL = 2'b10,
      WINNED       = 2'b11
   } game_status_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } stats_state_t;

   localparam logic [15:0] BCD_NONE = 16'h9999;

   function automatic logic [3:0] bcd_tens(input int v);
      return 4'((v / 10) % 10);
   endfunction

   function automatic logic [3:0] bcd_units(input int v);
      return 4'(v % 10);
   endfunction

endpackage

// File: rtl/game_stats_bcd_digit_cnt.sv
// One BCD digit: counts 0..WRAP when enabled, carries out on wrap,
// and exposes its next value so callers can see a result one cycle early.
module bcd_digit_cnt #(
   parameter logic [3:0] WRAP = 4'd9
) (
   input  logic       clk_d,
   input  logic       rst,
   input  logic       en,
   input  logic       clr,
   output logic [3:0] q,
   output logic [3:0] q_nxt,
   output logic       co
);

   always_comb begin
      co = en && (q == WRAP);
      if (clr)
         q_nxt = '0;
      else if (co)
         q_nxt = '0;
      else if (en)
         q_nxt = q + 4'd1;
      else
         q_nxt = q;
   end

   always_ff @(posedge clk_d or posedge rst) begin
      if (rst)
         q <= '0;
      else
         q <= q_nxt;
   end

endmodule

// File: rtl/game_stats.sv
// Per-game statistics: BCD move counter, mm:ss play timer and the best
// (lowest) winning move count since reset, driven by the game phase.
module game_stats
   import game_stats_pkg::*;
#(
   parameter int CLK_HZ  = 1000,
   parameter int MAX_MIN = 59
) (
   input  logic        clk_d,
   input  logic        rst,
   input  logic [1:0]  game_status,
   input  logic        active,
   input  logic        win_flag,
   output logic [15:0] step_bcd,
   output logic [15:0] time_bcd,
   output logic [15:0] best_bcd,
   output logic        best_valid,
   output logic        new_best,
   output logic        running
);

   localparam int              PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]   PRE_TC   = PW'(CLK_HZ - 1);
   localparam logic [15:0]     TIME_SAT = {bcd_tens(MAX_MIN), bcd_units(MAX_MIN), 4'd5, 4'd9};
   // Wrap value per time digit, LSB first: sec units, sec tens, min units, min tens.
   localparam logic [3:0][3:0] TWRAP    = {4'd9, 4'd9, 4'd5, 4'd9};

   game_status_t    gs;
   stats_state_t    state, state_nxt;
   logic            leave, start, finish, in_run;
   logic            step_inc, sec_tick;
   logic [PW-1:0]   presc;
   logic [3:0][3:0] step_q, step_d, time_q, time_d;
   logic [4:0]      step_en, time_en;
   logic            unused_bits;

   assign gs    = game_status_t'(game_status);
   assign leave = (gs == CHOSE_BOARD) || (gs == GAME_INITIAL);

   always_ff @(posedge clk_d or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gs == GAMING) state_nxt = RUN;
         RUN:     if (leave) state_nxt = IDLE;
                  else if (win_flag || gs == WINNED) state_nxt = DONE;
         DONE:    if (leave) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_run = (state == RUN);
      start  = (state == IDLE) && (state_nxt == RUN);
      finish = (state == RUN) && (state_nxt == DONE);
   end

   // Moves and ticks still count in the RUN->DONE cycle itself.
   assign step_inc   = in_run && active && (step_q != BCD_NONE);
   assign sec_tick   = in_run && (presc == PRE_TC) && (time_q != TIME_SAT);
   assign step_en[0] = step_inc;
   assign time_en[0] = sec_tick;

   for (genvar i = 0; i < 4; i++) begin : g_step
      bcd_digit_cnt #(.WRAP(4'd9)) u_digit (
         .clk_d (clk_d),
         .rst   (rst),
         .en    (step_en[i]),
         .clr   (start),
         .q     (step_q[i]),
         .q_nxt (step_d[i]),
         .co    (step_en[i+1])
      );
   end

   for (genvar i = 0; i < 4; i++) begin : g_time
      bcd_digit_cnt #(.WRAP(TWRAP[i])) u_digit (
         .clk_d (clk_d),
         .rst   (rst),
         .en    (time_en[i]),
         .clr   (start),
         .q     (time_q[i]),
         .q_nxt (time_d[i]),
         .co    (time_en[i+1])
      );
   end

   assign unused_bits = ^{step_en[4], time_en[4], time_d};

   always_ff @(posedge clk_d or posedge rst) begin
      if (rst)
         presc <= '0;
      else if (start)
         presc <= '0;
      else if (in_run)
         presc <= (presc == PRE_TC) ? '0 : presc + PW'(1);
   end

   // step_d already includes a move taken in the finishing cycle.
   always_ff @(posedge clk_d or posedge rst) begin
      if (rst) begin
         best_bcd   <= BCD_NONE;
         best_valid <= 1'b0;
         new_best   <= 1'b0;
         running    <= 1'b0;
      end else begin
         new_best <= 1'b0;
         running  <= (state_nxt == RUN);
         if (finish && (!best_valid || step_d < best_bcd)) begin
            best_bcd   <= step_d;
            best_valid <= 1'b1;
            new_best   <= 1'b1;
         end
      end
   end

   assign step_bcd = step_q;
   assign time_bcd = time_q;

endmodule

// File: tb/tb_game_stats.sv
// Bench for game_stats: two instances (fast timer, and 1 Hz with a 1-minute
// cap) share stimulus and are compared every cycle with an integer model.
module tb_game_stats;
   import game_stats_pkg::*;

   logic       clk_d = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] game_status = CHOSE_BOARD;
   logic       active = 1'b0;
   logic       win_flag = 1'b0;
   logic       chk_en = 1'b0;

   logic [15:0] step_a, time_a, best_a, step_b, time_b, best_b;
   logic        bv_a, nb_a, run_a, bv_b, nb_b, run_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_d = ~clk_d;

   game_stats #(.CLK_HZ(4), .MAX_MIN(59)) dut_a (
      .clk_d(clk_d), .rst(rst), .game_status(game_status), .active(active),
      .win_flag(win_flag), .step_bcd(step_a), .time_bcd(time_a), .best_bcd(best_a),
      .best_valid(bv_a), .new_best(nb_a), .running(run_a)
   );

   game_stats #(.CLK_HZ(1), .MAX_MIN(1)) dut_b (
      .clk_d(clk_d), .rst(rst), .game_status(game_status), .active(active),
      .win_flag(win_flag), .step_bcd(step_b), .time_bcd(time_b), .best_bcd(best_b),
      .best_valid(bv_b), .new_best(nb_b), .running(run_b)
   );

   // Model: per instance, a game phase (0 idle, 1 run, 2 done), plain integer
   // move count, total seconds, clock-cycle prescale and best score.
   int m_state[2], m_step[2], m_secs[2], m_presc[2], m_best[2];
   bit m_bv[2], m_nb[2];
   int hz[2]    = '{4, 1};
   int maxs[2]  = '{59 * 60 + 59, 1 * 60 + 59};
   logic leave_g, goal_g;

   assign leave_g = (game_status == CHOSE_BOARD) || (game_status == GAME_INITIAL);
   assign goal_g  = win_flag || (game_status == WINNED);

   always @(posedge clk_d or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_state[k] = 0; m_step[k] = 0; m_secs[k] = 0; m_presc[k] = 0;
            m_best[k] = 9999; m_bv[k] = 1'b0; m_nb[k] = 1'b0;
         end else begin
            m_nb[k] = 1'b0;
            if (m_state[k] == 1) begin
               if (active && m_step[k] < 9999) m_step[k]++;
               m_presc[k]++;
               if (m_presc[k] == hz[k]) begin
                  m_presc[k] = 0;
                  if (m_secs[k] < maxs[k]) m_secs[k]++;
               end
               if (leave_g)
                  m_state[k] = 0;
               else if (goal_g) begin
                  m_state[k] = 2;
                  if (!m_bv[k] || m_step[k] < m_best[k]) begin
                     m_best[k] = m_step[k]; m_bv[k] = 1'b1; m_nb[k] = 1'b1;
                  end
               end
            end else if (m_state[k] == 0) begin
               if (game_status == GAMING) begin
                  m_state[k] = 1; m_step[k] = 0; m_secs[k] = 0; m_presc[k] = 0;
               end
            end else if (leave_g) begin
               m_state[k] = 0;
            end
         end
      end
   end

   function automatic logic [15:0] to_bcd(input int v);
      return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [15:0] secs_bcd(input int s);
      int mm, ss;
      mm = s / 60;
      ss = s % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk_d) begin
      if (chk_en) begin
         check("a.step", step_a, to_bcd(m_step[0]));
         check("a.time", time_a, secs_bcd(m_secs[0]));
         check("a.best", best_a, to_bcd(m_best[0]));
         check("a.valid", 16'(bv_a), 16'(m_bv[0]));
         check("a.new_best", 16'(nb_a), 16'(m_nb[0]));
         check("a.running", 16'(run_a), 16'(m_state[0] == 1));
         check("b.step", step_b, to_bcd(m_step[1]));
         check("b.time", time_b, secs_bcd(m_secs[1]));
         check("b.best", best_b, to_bcd(m_best[1]));
         check("b.valid", 16'(bv_b), 16'(m_bv[1]));
         check("b.new_best", 16'(nb_b), 16'(m_nb[1]));
         check("b.running", 16'(run_b), 16'(m_state[1] == 1));
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_d);
         #2;
      end
   endtask

   task automatic pulses(input int n);
      repeat (n) begin
         active = 1'b1; tick(1);
         active = 1'b0; tick(1);
      end
   endtask

   task automatic new_game();
      game_status = GAME_INITIAL; tick(2);
      game_status = GAMING;       tick(1);
   endtask

   task automatic win();
      win_flag = 1'b1; tick(1);
      win_flag = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b1;
      chk_en = 1'b1;
      tick(2);
      @(negedge clk_d);
      check("rst.step", step_a, 16'h0000);
      check("rst.time", time_a, 16'h0000);
      check("rst.best", best_a, 16'h9999);
      check("rst.valid", 16'(bv_a), 16'h0000);
      check("rst.running", 16'(run_a), 16'h0000);
      tick(1);
      rst = 1'b0;
      tick(1);

      // Scenario 1 and 2: 300 cycles in RUN at 4 Hz make 75 s.
      new_game();
      pulses(12);
      @(negedge clk_d);
      check("s1.step", step_a, 16'h0012);
      check("s1.model_step", to_bcd(m_step[0]), 16'h0012);
      check("s1.running", 16'(run_a), 16'h0001);
      tick(276);
      @(negedge clk_d);
      check("s2.time", time_a, 16'h0115);
      check("s2.model_time", secs_bcd(m_secs[0]), 16'h0115);
      win();
      @(negedge clk_d);
      check("s2.running", 16'(run_a), 16'h0000);
      check("s2.best", best_a, 16'h0012);
      check("s2.new_best", 16'(nb_a), 16'h0001);
      tick(1);
      @(negedge clk_d);
      check("s2.new_best_off", 16'(nb_a), 16'h0000);
      tick(4);
      @(negedge clk_d);
      check("s2.time_frozen", time_a, 16'h0115);
      check("s2.step_frozen", step_a, 16'h0012);

      // Scenario 3: better score, then a tie.
      new_game();
      pulses(9);
      win();
      @(negedge clk_d);
      check("s3.best", best_a, 16'h0009);
      check("s3.new_best", 16'(nb_a), 16'h0001);
      new_game();
      pulses(9);
      win();
      @(negedge clk_d);
      check("s3.tie_best", best_a, 16'h0009);
      check("s3.tie_no_pulse", 16'(nb_a), 16'h0000);
      check("s3.model_best", to_bcd(m_best[0]), 16'h0009);

      // Scenario 5: move counted in the winning cycle.
      new_game();
      pulses(4);
      active = 1'b1; win_flag = 1'b1; tick(1);
      active = 1'b0; win_flag = 1'b0;
      @(negedge clk_d);
      check("s5.step", step_a, 16'h0005);
      check("s5.best", best_a, 16'h0005);
      check("s5.new_best", 16'(nb_a), 16'h0001);

      // Scenario 6: reset in the middle of a game.
      new_game();
      pulses(7);
      tick(3);
      rst = 1'b1;
      @(negedge clk_d);
      check("s6.step", step_a, 16'h0000);
      check("s6.time", time_a, 16'h0000);
      check("s6.best", best_a, 16'h9999);
      check("s6.valid", 16'(bv_a), 16'h0000);
      check("s6.running", 16'(run_a), 16'h0000);
      tick(1);
      rst = 1'b0;

      // Scenario 4: step saturation and time saturation at 1:59.
      new_game();
      active = 1'b1; tick(9998);
      active = 1'b0;
      @(negedge clk_d);
      check("s4.step_9998", step_a, 16'h9998);
      pulses(3);
      @(negedge clk_d);
      check("s4.step_sat", step_a, 16'h9999);
      check("s4.time_sat", time_b, 16'h0159);

      // Random phase sequences, moves, wins and occasional resets.
      repeat (3000) begin
         int r;
         r = int'($urandom_range(0, 15));
         game_status = (r == 0) ? CHOSE_BOARD : (r == 1) ? GAME_INITIAL :
                       (r == 2) ? WINNED : GAMING;
         active   = ($urandom_range(0, 2) == 0);
         win_flag = ($urandom_range(0, 39) == 0);
         rst      = ($urandom_range(0, 799) == 0);
         tick(1);
      end
      rst = 1'b0; active = 1'b0; win_flag = 1'b0;
      tick(2);
      @(negedge clk_d);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
